// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register file writeback merging ALU results with one outstanding load
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   alu_valid/rd/result single-cycle ALU result, highest priority on the write port
//   ld_req_valid/ready  load issue handshake (one load in flight at a time)
//   ld_rd/funct3        load destination and RV32I load type
//   ld_byte_offset      address bits [1:0] selecting the byte/halfword lane
//   mem_rsp_valid/data  aligned memory word returned for the pending load
//   rs1/rs2_address     decode source registers checked against pending loads
//   hazard_stall        combinational stall request to decode
//   rf_en/rd/data       registered register file write port

module regfile_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        ld_req_valid,
  output logic        ld_req_ready,
  input  logic [4:0]  ld_rd,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_byte_offset,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic [4:0]  rs1_address,
  input  logic [4:0]  rs2_address,
  output logic        hazard_stall,
  output logic        rf_en,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_WRITE    = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  state_t      state;
  state_t      state_next;

  logic        load_accept;
  logic        rsp_capture;
  logic        load_commit;

  logic [4:0]  pend_rd;
  logic [2:0]  pend_funct3;
  logic [1:0]  pend_offset;
  logic [31:0] load_buf;
  logic        squash;
  logic [31:0] scoreboard;

  // Lane select and extension of an aligned memory word. Unknown funct3
  // encodings fall through to a full-word load.
  function automatic logic [31:0] extract_load(input logic [2:0]  funct3,
                                               input logic [1:0]  offset,
                                               input logic [31:0] word);
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    byte_val = word[{offset, 3'b000} +: 8];
    half_val = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   extract_load = {{24{byte_val[7]}}, byte_val};
      F3_LH:   extract_load = {{16{half_val[15]}}, half_val};
      F3_LBU:  extract_load = {24'd0, byte_val};
      F3_LHU:  extract_load = {16'd0, half_val};
      default: extract_load = word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    ld_req_ready = 1'b0;
    load_accept  = 1'b0;
    rsp_capture  = 1'b0;
    load_commit  = 1'b0;
    case (state)
      S_IDLE: begin
        ld_req_ready = 1'b1;
        if (ld_req_valid) begin
          load_accept = 1'b1;
          state_next  = S_WAIT_MEM;
        end
      end
      S_WAIT_MEM: begin
        if (mem_rsp_valid) begin
          rsp_capture = 1'b1;
          state_next  = S_WRITE;
        end
      end
      S_WRITE: begin
        // The ALU owns the port whenever it has a result; the load waits.
        if (!alu_valid) begin
          load_commit = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_rd     <= 5'd0;
      pend_funct3 <= 3'd0;
      pend_offset <= 2'd0;
      load_buf    <= 32'd0;
      squash      <= 1'b0;
      scoreboard  <= 32'd0;
      rf_en       <= 1'b0;
      rf_rd       <= 5'd0;
      rf_data     <= 32'd0;
    end else begin
      if (load_accept) begin
        pend_rd     <= ld_rd;
        pend_funct3 <= ld_funct3;
        pend_offset <= ld_byte_offset;
        // An ALU write in the accept cycle is older than the load, so it
        // must not squash it.
        squash      <= 1'b0;
        if (ld_rd != 5'd0) begin
          scoreboard[ld_rd] <= 1'b1;
        end
      end

      if (rsp_capture) begin
        load_buf <= extract_load(pend_funct3, pend_offset, mem_rsp_data);
      end

      // A younger ALU write to the load's destination makes the load value
      // stale; the load still completes but its write is dropped.
      if ((state == S_WAIT_MEM || state == S_WRITE) && alu_valid && (alu_rd == pend_rd)) begin
        squash <= 1'b1;
      end

      if (load_commit) begin
        scoreboard[pend_rd] <= 1'b0;
      end

      if (alu_valid) begin
        rf_en   <= (alu_rd != 5'd0);
        rf_rd   <= alu_rd;
        rf_data <= alu_result;
      end else if (load_commit) begin
        rf_en   <= (pend_rd != 5'd0) && !squash;
        rf_rd   <= pend_rd;
        rf_data <= load_buf;
      end else begin
        rf_en   <= 1'b0;
      end
    end
  end

  always_comb begin
    hazard_stall = ((rs1_address != 5'd0) && scoreboard[rs1_address]) ||
                   ((rs2_address != 5'd0) && scoreboard[rs2_address]);
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - self-checking bench for regfile_writeback

module tb_regfile_writeback;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_byte_offset;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  rs1_address;
  logic [4:0]  rs2_address;
  logic        hazard_stall;
  logic        rf_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;

  regfile_writeback dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_result     (alu_result),
    .ld_req_valid   (ld_req_valid),
    .ld_req_ready   (ld_req_ready),
    .ld_rd          (ld_rd),
    .ld_funct3      (ld_funct3),
    .ld_byte_offset (ld_byte_offset),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .rs1_address    (rs1_address),
    .rs2_address    (rs2_address),
    .hazard_stall   (hazard_stall),
    .rf_en          (rf_en),
    .rf_rd          (rf_rd),
    .rf_data        (rf_data)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] word;
    logic [31:0] exp;
  } vec_t;

  wb_t  exp_q[$];
  vec_t vecs[12];
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every register file write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && rf_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", rf_rd, rf_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, rf_rd}, {27'd0, e.rd});
        chk("wb_data", rf_data, e.data);
      end
    end
  end

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] word, input int lat, input logic [31:0] exp);
    ld_req_valid   = 1'b1;
    ld_rd          = rd;
    ld_funct3      = f3;
    ld_byte_offset = off;
    rs1_address    = rd;
    rs2_address    = 5'd0;
    chk("ready_idle", {31'd0, ld_req_ready}, 32'd1);
    tick();
    ld_req_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      chk("stall_wait", {31'd0, hazard_stall}, {31'd0, rd != 5'd0});
      chk("ready_wait", {31'd0, ld_req_ready}, 32'd0);
      tick();
    end
    chk("stall_rsp", {31'd0, hazard_stall}, {31'd0, rd != 5'd0});
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = word;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = $urandom;
    chk("ready_write", {31'd0, ld_req_ready}, 32'd0);
    chk("stall_write", {31'd0, hazard_stall}, {31'd0, rd != 5'd0});
    if (rd != 5'd0) push_wb(rd, exp);
    tick();
    chk("ready_done", {31'd0, ld_req_ready}, 32'd1);
    chk("stall_done", {31'd0, hazard_stall}, 32'd0);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{3'b000, 2'd3, 5'd1,  32'h80FF_7F01, 32'hFFFF_FF80};
    vecs[1]  = '{3'b100, 2'd3, 5'd2,  32'h80FF_7F01, 32'h0000_0080};
    vecs[2]  = '{3'b001, 2'd2, 5'd3,  32'h80FF_7F01, 32'hFFFF_80FF};
    vecs[3]  = '{3'b101, 2'd0, 5'd4,  32'h80FF_7F01, 32'h0000_7F01};
    vecs[4]  = '{3'b010, 2'd1, 5'd5,  32'h80FF_7F01, 32'h80FF_7F01};
    vecs[5]  = '{3'b000, 2'd0, 5'd6,  32'h80FF_7F01, 32'h0000_0001};
    vecs[6]  = '{3'b000, 2'd2, 5'd12, 32'h80FF_7F01, 32'hFFFF_FFFF};
    vecs[7]  = '{3'b100, 2'd1, 5'd13, 32'h80FF_7F01, 32'h0000_007F};
    vecs[8]  = '{3'b101, 2'd2, 5'd14, 32'h80FF_7F01, 32'h0000_80FF};
    vecs[9]  = '{3'b001, 2'd3, 5'd31, 32'h1234_8001, 32'h0000_1234};
    vecs[10] = '{3'b011, 2'd2, 5'd15, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[11] = '{3'b010, 2'd0, 5'd0,  32'h5555_AAAA, 32'h0000_0000};

    rst            = 1'b1;
    alu_valid      = 1'b0;
    alu_rd         = 5'd0;
    alu_result     = 32'd0;
    ld_req_valid   = 1'b0;
    ld_rd          = 5'd0;
    ld_funct3      = 3'd0;
    ld_byte_offset = 2'd0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'd0;
    rs1_address    = 5'd0;
    rs2_address    = 5'd0;
    repeat (3) tick();
    rst = 1'b0;

    chk("reset_rf_en", {31'd0, rf_en}, 32'd0);
    chk("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("reset_rf_data", rf_data, 32'd0);
    chk("reset_ready", {31'd0, ld_req_ready}, 32'd1);
    chk("reset_stall", {31'd0, hazard_stall}, 32'd0);

    // ALU write, then ALU to x0 produces no write.
    alu_valid  = 1'b1;
    alu_rd     = 5'd5;
    alu_result = 32'h1234_5678;
    push_wb(5'd5, 32'h1234_5678);
    tick();
    alu_rd     = 5'd0;
    alu_result = 32'hDEAD_0000;
    tick();
    alu_valid = 1'b0;
    chk("alu_x0_no_write", {31'd0, rf_en}, 32'd0);
    tick();

    // Load extension table with varying memory latency.
    for (int i = 0; i < 12; i++) begin
      do_load(vecs[i].rd, vecs[i].f3, vecs[i].off, vecs[i].word, i % 3, vecs[i].exp);
    end

    // Hazard on rs1/rs2 with a pending load to x7.
    ld_req_valid = 1'b1; ld_rd = 5'd7; ld_funct3 = 3'b010; ld_byte_offset = 2'd0;
    tick();
    ld_req_valid = 1'b0;
    rs1_address = 5'd0; rs2_address = 5'd0;
    #1 chk("haz_none", {31'd0, hazard_stall}, 32'd0);
    rs2_address = 5'd7;
    #1 chk("haz_rs2", {31'd0, hazard_stall}, 32'd1);
    rs1_address = 5'd7; rs2_address = 5'd0;
    #1 chk("haz_rs1", {31'd0, hazard_stall}, 32'd1);
    rs1_address = 5'd8;
    #1 chk("haz_other", {31'd0, hazard_stall}, 32'd0);
    rs1_address = 5'd7;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0707_0707;
    tick();
    mem_rsp_valid = 1'b0;
    push_wb(5'd7, 32'h0707_0707);
    chk("haz_write_cycle", {31'd0, hazard_stall}, 32'd1);
    tick();
    chk("haz_cleared", {31'd0, hazard_stall}, 32'd0);
    tick();

    // Port conflict: two ALU writes during WRITE; stray response ignored.
    ld_req_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b101; ld_byte_offset = 2'd2;
    rs1_address = 5'd4;
    tick();
    ld_req_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h80FF_7F01;
    tick();
    mem_rsp_data = 32'hDEAD_BEEF;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_result = 32'h1111_1111;
    push_wb(5'd3, 32'h1111_1111);
    chk("pc_ready_1", {31'd0, ld_req_ready}, 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    alu_result = 32'h2222_2222;
    push_wb(5'd3, 32'h2222_2222);
    chk("pc_ready_2", {31'd0, ld_req_ready}, 32'd0);
    chk("pc_stall_2", {31'd0, hazard_stall}, 32'd1);
    tick();
    alu_valid = 1'b0;
    push_wb(5'd4, 32'h0000_80FF);
    chk("pc_ready_3", {31'd0, ld_req_ready}, 32'd0);
    tick();
    chk("pc_ready_done", {31'd0, ld_req_ready}, 32'd1);
    chk("pc_stall_done", {31'd0, hazard_stall}, 32'd0);
    tick();

    // WAW squash from WAIT_MEM: ALU x9 survives, load write dropped.
    ld_req_valid = 1'b1; ld_rd = 5'd9; ld_funct3 = 3'b010; ld_byte_offset = 2'd0;
    rs1_address = 5'd9;
    tick();
    ld_req_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 32'hAAAA_AAAA;
    push_wb(5'd9, 32'hAAAA_AAAA);
    tick();
    alu_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    chk("waw_stall_write", {31'd0, hazard_stall}, 32'd1);
    tick();
    chk("waw_stall_clear", {31'd0, hazard_stall}, 32'd0);
    chk("waw_ready", {31'd0, ld_req_ready}, 32'd1);
    repeat (2) tick();

    // WAW squash from WRITE: ALU wins the port and the load is dropped.
    ld_req_valid = 1'b1; ld_rd = 5'd10; ld_funct3 = 3'b010;
    rs1_address = 5'd10;
    tick();
    ld_req_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BAD_0BAD;
    tick();
    mem_rsp_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_result = 32'hBBBB_BBBB;
    push_wb(5'd10, 32'hBBBB_BBBB);
    tick();
    alu_valid = 1'b0;
    tick();
    chk("waw2_stall_clear", {31'd0, hazard_stall}, 32'd0);
    repeat (2) tick();

    // Same-cycle accept and ALU to same rd: ALU first, load later, no squash.
    ld_req_valid = 1'b1; ld_rd = 5'd6; ld_funct3 = 3'b010;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_result = 32'h6666_6666;
    push_wb(5'd6, 32'h6666_6666);
    tick();
    ld_req_valid = 1'b0; alu_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h80FF_7F01;
    tick();
    mem_rsp_valid = 1'b0;
    push_wb(5'd6, 32'h80FF_7F01);
    repeat (3) tick();

    // Reset mid-load: late response ignored.
    ld_req_valid = 1'b1; ld_rd = 5'd11; ld_funct3 = 3'b010;
    rs1_address = 5'd11;
    tick();
    ld_req_valid = 1'b0;
    chk("rst_stall_pending", {31'd0, hazard_stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_7777;
    chk("rst_stall_clear", {31'd0, hazard_stall}, 32'd0);
    chk("rst_ready", {31'd0, ld_req_ready}, 32'd1);
    tick();
    mem_rsp_valid = 1'b0;
    chk("rst_ready_after_rsp", {31'd0, ld_req_ready}, 32'd1);
    chk("rst_no_write", {31'd0, rf_en}, 32'd0);
    repeat (3) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback controller driving the register file write port (`en`, `rd`, write data) and feeding the read side's hazard check. It merges single-cycle ALU results with one outstanding multi-cycle load at a time. It sign- or zero-extends load data and tracks registers with a pending load in a 32-bit scoreboard. Decode uses the resulting stall output to hold any instruction whose source register is still pending.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU result present this cycle.
- `alu_rd`  in  5  ALU destination register.
- `alu_result`  in  32  ALU result.
- `ld_req_valid`  in  1  load issue request.
- `ld_req_ready`  out  1  load accepted when `ld_req_valid` and `ld_req_ready` are both high.
- `ld_rd`  in  5  load destination register.
- `ld_funct3`  in  3  load type (RV32I encoding).
- `ld_byte_offset`  in  2  address bits [1:0].
- `mem_rsp_valid`  in  1  memory read data valid.
- `mem_rsp_data`  in  32  aligned memory word.
- `rs1_address`  in  5  decode source register 1.
- `rs2_address`  in  5  decode source register 2.
- `hazard_stall`  out  1  combinational stall request to decode.
- `rf_en`  out  1  register file write enable (registered).
- `rf_rd`  out  5  register file destination (registered).
- `rf_data`  out  32  register file write data (registered).

## Operation
State machine:
- IDLE
  - `ld_req_ready`=1.
  - On accept: capture rd, funct3 and offset; set `scoreboard[ld_rd]` if `ld_rd`≠0; clear `squash`; go to WAIT_MEM.
- WAIT_MEM
  - `ld_req_ready`=0.
  - On `mem_rsp_valid`: store the extracted load value in `load_buf`; go to WRITE.
- WRITE
  - `ld_req_ready`=0.
  - If `alu_valid`=0: write `load_buf` to the captured rd (suppressed if rd=0 or `squash`=1); clear the scoreboard bit; go to IDLE.
  - If `alu_valid`=1: stay in WRITE; the ALU wins the port.

ALU path:
- `alu_valid` with `alu_rd`≠0 → next cycle `rf_en`=1, `rf_rd`=`alu_rd`, `rf_data`=`alu_result`.
- `alu_rd`=0 → `rf_en`=0.
- ALU always has priority over the load write.

Load extraction (funct3):
- 000 LB: sign-extend the byte selected by offset.
- 001 LH: sign-extend the halfword selected by offset[1].
- 010 LW: full word; offset ignored.
- 100 LBU: zero-extend the selected byte.
- 101 LHU: zero-extend the selected halfword.
- Any other funct3 is treated as LW.

Hazard and squash:
- `hazard_stall` = (`rs1_address`≠0 & `scoreboard[rs1_address]`) | (`rs2_address`≠0 & `scoreboard[rs2_address]`).
- Scoreboard bit 0 is never set.
- WAW: `alu_valid` with `alu_rd` equal to the pending load rd, while in WAIT_MEM or WRITE, sets `squash`. The ALU instruction is younger and its value must survive.
- The scoreboard bit stays set until the load leaves WRITE.
- Same-cycle load accept and ALU write to the same rd: the ALU is older; no squash. The ALU writes first and the load writes later.
- `mem_rsp_valid` in IDLE or WRITE is ignored.

Reset:
- `rf_en`=0, `rf_rd`=0, `rf_data`=0.
- State goes to IDLE; scoreboard=0; `squash`=0; `load_buf`=0; `ld_req_ready`=1 the cycle after reset deasserts.
- Reset mid-load abandons the load; a response arriving after reset is ignored.

## Timing
- ALU: `alu_valid` in cycle N → `rf_en` high in N+1 for one cycle.
- Load:
  - Accept in cycle A.
  - `mem_rsp_valid` is honored only from A+1.
  - Response in cycle M → WRITE in M+1.
  - If no ALU in M+1: `rf_en` in M+2; scoreboard cleared and `hazard_stall` low in M+2; `ld_req_ready` high in M+2.
- Each cycle of `alu_valid` during WRITE delays the load write by one cycle.
- `hazard_stall` is combinational from `rs1_address`/`rs2_address` and the scoreboard. It rises in A+1 for the accepted rd.
- Minimum load-to-reuse: a new load accepts in M+2; back-to-back load occupancy is 3 cycles plus memory latency.

## Test plan
- ALU write: `alu_valid`=1, `alu_rd`=5, `alu_result`=0x1234_5678 → next cycle `rf_en`=1, `rf_rd`=5, `rf_data`=0x1234_5678. Repeating with `alu_rd`=0 → `rf_en`=0.
- Load extension: `mem_rsp_data`=0x80FF_7F01. Expected `rf_data` per case:
  - LB offset 3 → 0xFFFF_FF80.
  - LBU offset 3 → 0x0000_0080.
  - LH offset 2 → 0xFFFF_80FF.
  - LHU offset 0 → 0x0000_7F01.
  - LW → 0x80FF_7F01.
- Hazard:
  - Load rd=7 accepted; `rs1_address`=7 → `hazard_stall`=1 until the write cycle, then 0.
  - `rs2_address`=0 with any pending load → `hazard_stall`=0.
- Port conflict:
  - Load in WRITE while `alu_valid`=1 for 2 cycles (rd=3) → two ALU writes first.
  - Then the load write to its rd, with `ld_req_ready` low throughout.
- WAW squash: load rd=9 pending; ALU writes x9=0xAAAA_AAAA → load completes with no `rf_en`; x9 stays 0xAAAA_AAAA; scoreboard bit 9 clears.
- Reset mid-load: assert `rst` in WAIT_MEM, then send `mem_rsp_valid` → no `rf_en`; `hazard_stall`=0; `ld_req_ready`=1.
